alu_result_stage: RTL and testbench
===================================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter WIDTH, default 16, data width of every unit result and of ALU_OUT.
REQ-002 Parameter DEPTH, default 4, output FIFO entries; legal values 2, 4, 8.
REQ-003 Clock and reset are one clock and one asynchronous active-high reset.
REQ-004 CLK  in  1  rising-edge clock for all state.
REQ-005 RST  in  1  asynchronous, active-high reset.
REQ-006 Enable  in  4  one-hot unit select from the 2x4 function decoder: bit3 arith, bit2 logic, bit1 compare, bit0 shift; 4'b0000 = idle.
REQ-007 Arith_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT  in  WIDTH each  unit results.
REQ-008 Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  in  1 each  unit result-valid strobes, one cycle per result.
REQ-009 OUT_Ready  in  1  consumer accepts head entry.
REQ-010 ALU_OUT  out  WIDTH  head result.
REQ-011 OUT_Unit  out  2  head unit code: 00 arith, 01 logic, 10 compare, 11 shift.
REQ-012 OUT_Valid  out  1  FIFO non-empty.
REQ-013 Full  out  1  FIFO holds DEPTH entries.
REQ-014 Overflow  out  1  sticky: a valid result was dropped.
REQ-015 Err  out  1  sticky: protocol violation (REQ-019..REQ-021).

Function
REQ-016 Pending tag: on a rising edge with Enable one-hot, the stage SHALL store the unit code and set Pending.
REQ-017 Capture: a cycle with exactly one Flag high, Pending set and Flag matching the tag SHALL push {unit code, that unit's result} and clear Pending at the same edge.
REQ-018 Flag and a new one-hot Enable in the same cycle: the Flag SHALL be checked against the old tag, then the tag/Pending SHALL take the new Enable.
REQ-019 Enable neither one-hot nor zero SHALL set Err; tag and Pending unchanged.
REQ-020 Two or more Flags high in one cycle SHALL set Err, push nothing, leave Pending unchanged.
REQ-021 A Flag with Pending clear or not matching the tag SHALL set Err and push nothing.
REQ-022 Pop SHALL occur on an edge with OUT_Valid and OUT_Ready both high.
REQ-023 Push when Full SHALL succeed only if a pop occurs in the same cycle; otherwise the result SHALL be dropped and Overflow set.
REQ-024 Push and pop in the same cycle SHALL leave the count unchanged; push into empty FIFO with OUT_Ready high SHALL not bypass (entry visible next cycle).
REQ-025 Latency: Flag in cycle N SHALL give OUT_Valid high with that result in cycle N+1 when FIFO was empty.
REQ-026 ALU_OUT and OUT_Unit SHALL show the head entry (show-ahead) and SHALL be all-zero when OUT_Valid is low.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-028 Entries SHALL leave in push order.

Reset
REQ-029 RST high SHALL immediately clear pointers, count, Pending, tag, Overflow, Err; outputs read ALU_OUT=0, OUT_Unit=0, OUT_Valid=0, Full=0.
REQ-030 RST asserted mid-operation SHALL discard all queued entries and any pending tag; a Flag in the first cycle after release with no new Enable SHALL set Err.
REQ-031 Overflow and Err SHALL clear only by RST.

Structure
REQ-032 Shared package alu_pkg SHALL hold WIDTH default, DEPTH default and unit-code constants UNIT_ARITH=00, UNIT_LOGIC=01, UNIT_CMP=10, UNIT_SHIFT=11.
REQ-033 The FIFO SHALL be one sub-module alu_result_fifo (push/pop/full/empty, WIDTH+2 bits); tag, checking and result muxing stay in the top.

Verification
REQ-034 Enable=1000 with A=0x0012 in arith, Arith_Flag next cycle with Arith_OUT=0x0012, OUT_Ready=1 -> OUT_Valid one cycle later, ALU_OUT=0x0012, OUT_Unit=00, popped next edge.
REQ-035 OUT_Ready=0, four logic ops results 0x0001..0x0004 -> Full=1 after fourth; fifth result 0x0005 dropped, Overflow=1; then drain reads 0x0001..0x0004 in order.
REQ-036 Full with OUT_Ready=1 and Shift_Flag same cycle -> count stays 4, Overflow stays 0, new entry last out.
REQ-037 Enable=1000 then CMP_Flag -> Err=1, no push; Enable=1100 -> Err=1; Arith_Flag+Logic_Flag together -> Err=1, no push.
REQ-038 Three entries queued, RST pulsed mid-cycle -> OUT_Valid, Full, Err, Overflow 0 immediately; Arith_Flag after release with no Enable -> Err=1.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared widths, unit codes and small decode helpers for the ALU
//            result stage.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_WIDTH = 16;
    localparam int ALU_DEPTH = 4;

    // Unit codes carried alongside every queued result
    typedef enum logic [1:0] {
        UNIT_ARITH = 2'b00,
        UNIT_LOGIC = 2'b01,
        UNIT_CMP   = 2'b10,
        UNIT_SHIFT = 2'b11
    } unit_e;

    // Number of bits set in a 4-bit select/strobe vector
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[3]} + {2'b00, v[2]} + {2'b00, v[1]} + {2'b00, v[0]};
    endfunction

    // Map a one-hot vector (bit3 arith .. bit0 shift) to its unit code.
    // Callers only trust the result when the vector is one-hot.
    function automatic unit_e onehot_to_unit(input logic [3:0] v);
        unit_e u;
        u = UNIT_ARITH;
        if (v[2]) u = UNIT_LOGIC;
        if (v[1]) u = UNIT_CMP;
        if (v[0]) u = UNIT_SHIFT;
        return u;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_fifo
// Brief    : Show-ahead synchronous FIFO for tagged results. A push while full
//            is accepted only if a pop happens on the same edge.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_fifo #(
    parameter int DATA_W = 18,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_empty,
    output logic              o_full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == C_FULL);
    assign w_do_pop  = i_pop && !w_empty;
    // Full only blocks the write when the head is not leaving this cycle
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Storage array; contents are don't-care while unoccupied, so no reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = w_empty ? '0 : r_mem[r_rptr];
    assign o_empty = w_empty;
    assign o_full  = w_full;

endmodule : alu_result_fifo
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_stage
// Brief    : Tracks which functional unit was enabled, checks the returning
//            result strobe against that tag, and queues {unit, result} in an
//            output FIFO. Protocol violations and drops raise sticky flags.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = ALU_DEPTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [3:0]       Enable,
    input  logic [WIDTH-1:0] Arith_OUT,
    input  logic [WIDTH-1:0] Logic_OUT,
    input  logic [WIDTH-1:0] CMP_OUT,
    input  logic [WIDTH-1:0] SHIFT_OUT,
    input  logic             Arith_Flag,
    input  logic             Logic_Flag,
    input  logic             CMP_Flag,
    input  logic             Shift_Flag,
    input  logic             OUT_Ready,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic [1:0]       OUT_Unit,
    output logic             OUT_Valid,
    output logic             Full,
    output logic             Overflow,
    output logic             Err
);

    logic       r_pending;
    unit_e      r_tag;
    logic       r_overflow;
    logic       r_err;

    logic [3:0]       w_flags;
    logic [2:0]       w_flag_cnt;
    logic [2:0]       w_en_cnt;
    logic             w_en_onehot;
    logic             w_en_bad;
    logic             w_flag_single;
    logic             w_flag_multi;
    unit_e            w_flag_unit;
    unit_e            w_en_unit;
    logic             w_match;
    logic             w_capture;
    logic             w_stray;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH+1:0] w_wdata;
    logic [WIDTH+1:0] w_rdata;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_drop;

    assign w_flags       = {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag};
    assign w_flag_cnt    = popcount4(w_flags);
    assign w_en_cnt      = popcount4(Enable);
    assign w_en_onehot   = (w_en_cnt == 3'd1);
    assign w_en_bad      = (w_en_cnt > 3'd1);
    assign w_flag_single = (w_flag_cnt == 3'd1);
    assign w_flag_multi  = (w_flag_cnt > 3'd1);
    assign w_flag_unit   = onehot_to_unit(w_flags);
    assign w_en_unit     = onehot_to_unit(Enable);

    // Strobes are always judged against the tag held before this edge
    assign w_match   = r_pending && (r_tag == w_flag_unit);
    assign w_capture = w_flag_single && w_match;
    assign w_stray   = w_flag_single && !w_match;

    // Select the reporting unit's result
    always_comb begin
        w_result = '0;
        case (w_flag_unit)
            UNIT_ARITH: w_result = Arith_OUT;
            UNIT_LOGIC: w_result = Logic_OUT;
            UNIT_CMP:   w_result = CMP_OUT;
            UNIT_SHIFT: w_result = SHIFT_OUT;
            default:    w_result = '0;
        endcase
    end

    assign w_wdata = {w_flag_unit, w_result};
    assign w_pop   = !w_empty && OUT_Ready;
    assign w_drop  = w_capture && w_full && !w_pop;

    // Pending tag: a new one-hot Enable wins over a same-cycle capture
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pending <= 1'b0;
            r_tag     <= UNIT_ARITH;
        end else if (w_en_onehot) begin
            r_pending <= 1'b1;
            r_tag     <= w_en_unit;
        end else if (w_capture) begin
            r_pending <= 1'b0;
        end
    end

    // Sticky status, cleared only by reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_overflow <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_drop) r_overflow <= 1'b1;
            if (w_en_bad || w_flag_multi || w_stray) r_err <= 1'b1;
        end
    end

    alu_result_fifo #(
        .DATA_W (WIDTH + 2),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .i_push  (w_capture),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign ALU_OUT   = w_rdata[WIDTH-1:0];
    assign OUT_Unit  = w_rdata[WIDTH+1:WIDTH];
    assign OUT_Valid = !w_empty;
    assign Full      = w_full;
    assign Overflow  = r_overflow;
    assign Err       = r_err;

endmodule : alu_result_stage
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_stage
// Brief    : Self-checking bench for alu_result_stage with a result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [3:0]  Enable = 4'b0000;
    logic [15:0] Arith_OUT = '0, Logic_OUT = '0, CMP_OUT = '0, SHIFT_OUT = '0;
    logic        Arith_Flag = 1'b0, Logic_Flag = 1'b0, CMP_Flag = 1'b0, Shift_Flag = 1'b0;
    logic        OUT_Ready = 1'b0;
    logic [15:0] ALU_OUT;
    logic [1:0]  OUT_Unit;
    logic        OUT_Valid, Full, Overflow, Err;

    int total = 0;
    int bad   = 0;
    logic [17:0] q[$];

    alu_result_stage #(.WIDTH(16), .DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .Enable(Enable),
        .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
        .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
        .OUT_Ready(OUT_Ready), .ALU_OUT(ALU_OUT), .OUT_Unit(OUT_Unit), .OUT_Valid(OUT_Valid),
        .Full(Full), .Overflow(Overflow), .Err(Err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        tick();
        RST = 1'b0;
        q.delete();
        Enable = 4'b0000;
        {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag} = 4'b0000;
        OUT_Ready = 1'b0;
    endtask

    // Enable a unit, then return its result one cycle later; other units
    // carry a distractor value so a wrong mux selection is visible.
    task automatic issue(input logic [3:0] en, input logic [15:0] val);
        Enable = en;
        tick();
        Enable = 4'b0000;
        {Arith_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT} = {4{~val}};
        case (en)
            4'b1000: begin Arith_OUT = val; Arith_Flag = 1'b1; end
            4'b0100: begin Logic_OUT = val; Logic_Flag = 1'b1; end
            4'b0010: begin CMP_OUT   = val; CMP_Flag   = 1'b1; end
            default: begin SHIFT_OUT = val; Shift_Flag = 1'b1; end
        endcase
        tick();
        {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag} = 4'b0000;
    endtask

    task automatic drain(input string name);
        logic [17:0] exp;
        OUT_Ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (OUT_Valid === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL %s_extra: got unit=%0d data=%h, expected nothing", name, OUT_Unit, ALU_OUT);
                end else begin
                    exp = q.pop_front();
                    if ({OUT_Unit, ALU_OUT} !== exp) begin
                        bad++;
                        $display("FAIL %s_order: got unit=%0d data=%h, expected unit=%0d data=%h",
                                 name, OUT_Unit, ALU_OUT, exp[17:16], exp[15:0]);
                    end
                end
            end else if (q.size() == 0) begin
                break;
            end
            tick();
        end
        total++;
        if (q.size() != 0 || OUT_Valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_leftover: %0d entries missing, OUT_Valid=%b, expected 0 and 0", name, q.size(), OUT_Valid);
        end
        OUT_Ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 RST = 1'b1;
        #1;
        total++;
        if ({ALU_OUT, OUT_Unit, OUT_Valid, Full, Overflow, Err} !== 22'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h, expected 0", {ALU_OUT, OUT_Unit, OUT_Valid, Full, Overflow, Err});
        end
        tick();
        tick();
        RST = 1'b0;
        tick();
        total++;
        if (OUT_Valid !== 1'b0 || Err !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: OUT_Valid=%b Err=%b, expected 0 0", OUT_Valid, Err);
        end
    endtask

    task automatic test_basic();
        do_reset();
        OUT_Ready = 1'b1;
        Enable = 4'b1000;
        tick();
        Enable = 4'b0000;
        {Logic_OUT, CMP_OUT, SHIFT_OUT} = {3{16'hFFED}};
        Arith_OUT  = 16'h0012;
        Arith_Flag = 1'b1;
        q.push_back({2'b00, 16'h0012});
        tick();
        Arith_Flag = 1'b0;
        total++;
        if (OUT_Valid !== 1'b1 || {OUT_Unit, ALU_OUT} !== q[0]) begin
            bad++;
            $display("FAIL basic_latency: valid=%b unit=%0d data=%h, expected 1 0 0012", OUT_Valid, OUT_Unit, ALU_OUT);
        end
        void'(q.pop_front());
        tick();
        total++;
        if (OUT_Valid !== 1'b0 || ALU_OUT !== 16'h0 || Err !== 1'b0) begin
            bad++;
            $display("FAIL basic_popped: valid=%b data=%h err=%b, expected 0 0000 0", OUT_Valid, ALU_OUT, Err);
        end
        OUT_Ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            issue(4'b0100, 16'(k));
            q.push_back({2'b01, 16'(k)});
            if (k == 3) begin
                total++;
                if (Full !== 1'b0) begin
                    bad++;
                    $display("FAIL ovf_not_full: Full=%b after 3, expected 0", Full);
                end
            end
        end
        total++;
        if (Full !== 1'b1 || Overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_full: Full=%b Overflow=%b, expected 1 0", Full, Overflow);
        end
        issue(4'b0100, 16'h0005);
        total++;
        if (Overflow !== 1'b1 || Err !== 1'b0 || Full !== 1'b1) begin
            bad++;
            $display("FAIL ovf_drop: Overflow=%b Err=%b Full=%b, expected 1 0 1", Overflow, Err, Full);
        end
        drain("ovf");
        total++;
        if (Overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky: Overflow=%b, expected 1", Overflow);
        end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            issue(4'b1000, 16'h0010 + 16'(k));
            q.push_back({2'b00, 16'h0010 + 16'(k)});
        end
        Enable = 4'b0001;
        tick();
        Enable = 4'b0000;
        {Arith_OUT, Logic_OUT, CMP_OUT} = {3{16'h5432}};
        SHIFT_OUT  = 16'hABCD;
        Shift_Flag = 1'b1;
        OUT_Ready  = 1'b1;
        total++;
        if ({OUT_Unit, ALU_OUT} !== q[0]) begin
            bad++;
            $display("FAIL fpp_head: got %h, expected %h", {OUT_Unit, ALU_OUT}, q[0]);
        end
        void'(q.pop_front());
        q.push_back({2'b11, 16'hABCD});
        tick();
        Shift_Flag = 1'b0;
        OUT_Ready  = 1'b0;
        total++;
        if (Full !== 1'b1 || Overflow !== 1'b0 || Err !== 1'b0) begin
            bad++;
            $display("FAIL fpp_status: Full=%b Overflow=%b Err=%b, expected 1 0 0", Full, Overflow, Err);
        end
        drain("fpp");
    endtask

    task automatic test_errors();
        do_reset();
        Enable = 4'b1000;
        tick();
        Enable = 4'b0000;
        CMP_Flag = 1'b1;
        tick();
        CMP_Flag = 1'b0;
        total++;
        if (Err !== 1'b1 || OUT_Valid !== 1'b0) begin
            bad++;
            $display("FAIL err_mismatch: Err=%b OUT_Valid=%b, expected 1 0", Err, OUT_Valid);
        end
        do_reset();
        Enable = 4'b1100;
        tick();
        Enable = 4'b0000;
        total++;
        if (Err !== 1'b1) begin
            bad++;
            $display("FAIL err_enable: Err=%b, expected 1", Err);
        end
        do_reset();
        Enable = 4'b1000;
        tick();
        Enable = 4'b0000;
        Arith_OUT = 16'h1111;
        Logic_OUT = 16'h2222;
        {Arith_Flag, Logic_Flag} = 2'b11;
        tick();
        {Arith_Flag, Logic_Flag} = 2'b00;
        total++;
        if (Err !== 1'b1 || OUT_Valid !== 1'b0) begin
            bad++;
            $display("FAIL err_multi: Err=%b OUT_Valid=%b, expected 1 0", Err, OUT_Valid);
        end
        // The arith tag must still be pending after the rejected double strobe
        Arith_Flag = 1'b1;
        q.push_back({2'b00, 16'h1111});
        tick();
        Arith_Flag = 1'b0;
        drain("err_pending");
    endtask

    task automatic test_back_to_back();
        do_reset();
        Enable = 4'b1000;
        tick();
        Arith_OUT  = 16'h0A0A;
        CMP_OUT    = 16'hF0F0;
        Arith_Flag = 1'b1;
        Enable     = 4'b0010;
        q.push_back({2'b00, 16'h0A0A});
        tick();
        Arith_Flag = 1'b0;
        Enable     = 4'b0000;
        CMP_OUT    = 16'h0C0C;
        CMP_Flag   = 1'b1;
        q.push_back({2'b10, 16'h0C0C});
        tick();
        CMP_Flag = 1'b0;
        total++;
        if (Err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_err: Err=%b, expected 0", Err);
        end
        drain("b2b");
    endtask

    task automatic test_reset_mid();
        do_reset();
        Enable = 4'b0110;
        tick();
        Enable = 4'b0000;
        for (int k = 0; k < 3; k++) issue(4'b0100, 16'h0100 + 16'(k));
        total++;
        if (OUT_Valid !== 1'b1 || Err !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre: OUT_Valid=%b Err=%b, expected 1 1", OUT_Valid, Err);
        end
        @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        total++;
        if ({OUT_Valid, Full, Err, Overflow} !== 4'b0000 || ALU_OUT !== 16'h0) begin
            bad++;
            $display("FAIL mid_async: valid/full/err/ovf=%b data=%h, expected 0000 0000",
                     {OUT_Valid, Full, Err, Overflow}, ALU_OUT);
        end
        @(posedge CLK);
        #1 RST = 1'b0;
        q.delete();
        Arith_OUT  = 16'h7777;
        Arith_Flag = 1'b1;
        tick();
        Arith_Flag = 1'b0;
        total++;
        if (Err !== 1'b1 || OUT_Valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_stray: Err=%b OUT_Valid=%b, expected 1 0", Err, OUT_Valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pushpop();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_result_stage
`default_nettype wire
